// File: rtl/writeback_queue.sv
// Writeback queue: merges ALU and load results into one register-file write per
// cycle, with youngest-match forwarding and a sticky overflow flag.
module writeback_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alu_valid,
   input  logic [4:0]               alu_rd,
   input  logic [31:0]              alu_data,
   input  logic                     mem_valid,
   input  logic [4:0]               mem_rd,
   input  logic [31:0]              mem_data,
   output logic                     in_ready,
   output logic                     write_reg,
   output logic [4:0]               write_reg_addr,
   output logic [31:0]              write_reg_data,
   input  logic [4:0]               fwd_addr,
   output logic                     fwd_hit,
   output logic [31:0]              fwd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic [4:0]       rd_q   [DEPTH];
   logic [4:0]       rd_d   [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [31:0]      data_d [DEPTH];

   logic             mem_en, alu_en, empty;
   logic [PTR_W-1:0] wr_ptr, fwd_idx;
   logic [CNT_W-1:0] enq_n, deq_n;

   assign empty          = (count_q == '0);
   assign in_ready       = (CNT_W'(DEPTH) - count_q) >= CNT_W'(2);
   assign write_reg      = !empty;
   assign write_reg_addr = empty ? '0 : rd_q[head_q];
   assign write_reg_data = empty ? '0 : data_q[head_q];
   assign count          = count_q;
   assign overflow       = overflow_q;

   assign mem_en = mem_valid && (mem_rd != '0);
   assign alu_en = alu_valid && (alu_rd != '0);

   // mem is written first so the ALU entry lands in the younger slot
   always_comb begin
      rd_d       = rd_q;
      data_d     = data_q;
      wr_ptr     = tail_q;
      enq_n      = '0;
      deq_n      = empty ? '0 : CNT_W'(1);
      overflow_d = overflow_q;
      if (in_ready) begin
         if (mem_en) begin
            rd_d[wr_ptr]   = mem_rd;
            data_d[wr_ptr] = mem_data;
            wr_ptr         = wr_ptr + PTR_W'(1);
            enq_n          = enq_n + CNT_W'(1);
         end
         if (alu_en) begin
            rd_d[wr_ptr]   = alu_rd;
            data_d[wr_ptr] = alu_data;
            wr_ptr         = wr_ptr + PTR_W'(1);
            enq_n          = enq_n + CNT_W'(1);
         end
      end else if (mem_en || alu_en) begin
         overflow_d = 1'b1;
      end
      tail_d  = wr_ptr;
      head_d  = empty ? head_q : head_q + PTR_W'(1);
      count_d = count_q + enq_n - deq_n;
   end

   // Oldest-to-youngest scan; the last match wins, so the youngest write forwards
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      fwd_idx  = head_q;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         fwd_idx = head_q + PTR_W'(i);
         if ((CNT_W'(i) < count_q) && (fwd_addr != '0) && (rd_q[fwd_idx] == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[fwd_idx];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            rd_q[i]   <= '0;
            data_q[i] <= '0;
         end
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         rd_q       <= rd_d;
         data_q     <= data_d;
      end
   end

endmodule
